// File: rtl/tick_sequencer_if.sv
// Configuration write port of tick_sequencer: one valid/ready transfer per channel config.
// The master drives the write; the sequencer (slave) answers with cfg_ready.
interface tick_sequencer_if #(
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_ch;
  logic [PERIOD_W-1:0] cfg_period;
  logic                cfg_oneshot;

  modport master (
    output cfg_valid, cfg_ch, cfg_period, cfg_oneshot,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_period, cfg_oneshot,
    output cfg_ready
  );
endinterface

// File: rtl/tick_sequencer.sv
// Multi-channel strobe scheduler sharing one prescaler; each channel emits one-cycle ticks.
// Optional macro TICK_SEQ_SYNC_START_EN: realign the prescaler when the first channel starts.
module tick_sequencer #(
  parameter int NUM_CH   = 4,
  parameter int BASE_DIV = 4,
  parameter int PERIOD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  tick_sequencer_if.slave   cfg,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  output logic              base_tick,
  output logic [NUM_CH-1:0] tick_out,
  output logic [NUM_CH-1:0] active,
  output logic [NUM_CH-1:0] done
);
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CH_SLOTS = 2 ** CH_W;
  localparam int DIV_W    = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BASE_DIV - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [DIV_W-1:0]    div_cnt_reg;
  logic [DIV_W-1:0]    div_cur;
  logic                div_wrap;
  logic                base_tick_reg;
  logic                presc_restart;
  logic [NUM_CH-1:0]   run_vec;
  logic [NUM_CH-1:0]   go_vec;
  logic [CH_SLOTS-1:0] run_pad;
  logic                cfg_wr;

  // Unused channel slots read as never running, so out-of-range writes are accepted.
  assign run_pad       = CH_SLOTS'(run_vec);
  assign cfg.cfg_ready = !run_pad[cfg.cfg_ch];
  assign cfg_wr        = cfg.cfg_valid && cfg.cfg_ready;

`ifdef TICK_SEQ_SYNC_START_EN
  assign presc_restart = (|go_vec) && !(|run_vec);
`else
  assign presc_restart = 1'b0;
`endif

  // A restart behaves like a step taken from count zero, so the first base tick of the
  // run arrives BASE_DIV-1 edges later and the first channel tick lands on P*BASE_DIV.
  assign div_cur  = presc_restart ? '0 : div_cnt_reg;
  assign div_wrap = (div_cur == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg   <= '0;
      base_tick_reg <= 1'b0;
    end else begin
      base_tick_reg <= div_wrap;
      div_cnt_reg   <= div_wrap ? '0 : div_cur + 1'b1;
    end
  end

  assign base_tick = base_tick_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [1:0]          state_reg;
      logic [PERIOD_W-1:0] period_reg;
      logic                oneshot_reg;
      logic [PERIOD_W-1:0] run_period_reg;
      logic                run_oneshot_reg;
      logic [PERIOD_W-1:0] cnt_reg;
      logic                tick_reg;
      logic                done_reg;
      logic                is_run;
      logic                cfg_hit;
      logic                go;
      logic                complete;

      assign is_run   = (state_reg == ST_RUN);
      assign cfg_hit  = cfg_wr && (cfg.cfg_ch == CH_W'(gi));
      assign go       = start[gi] && !stop[gi] && !is_run && (period_reg != '0);
      assign complete = is_run && base_tick_reg && (cnt_reg == run_period_reg - 1'b1);

      // The run latches its own copy of period/oneshot so a same-edge write only affects
      // the next start.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg       <= ST_IDLE;
          period_reg      <= '0;
          oneshot_reg     <= 1'b0;
          run_period_reg  <= '0;
          run_oneshot_reg <= 1'b0;
          cnt_reg         <= '0;
          tick_reg        <= 1'b0;
          done_reg        <= 1'b0;
        end else begin
          tick_reg <= 1'b0;
          if (cfg_hit) begin
            period_reg  <= cfg.cfg_period;
            oneshot_reg <= cfg.cfg_oneshot;
          end
          if (stop[gi]) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
          end else if (go) begin
            state_reg       <= ST_RUN;
            cnt_reg         <= '0;
            done_reg        <= 1'b0;
            run_period_reg  <= period_reg;
            run_oneshot_reg <= oneshot_reg;
          end else if (is_run && base_tick_reg) begin
            if (complete) begin
              tick_reg <= 1'b1;
              cnt_reg  <= '0;
              if (run_oneshot_reg) begin
                state_reg <= ST_DONE;
                done_reg  <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else if (cfg_hit) begin
            done_reg <= 1'b0;
          end
        end
      end

      assign run_vec[gi]  = is_run;
      assign go_vec[gi]   = go;
      assign tick_out[gi] = tick_reg;
      assign active[gi]   = is_run;
      assign done[gi]     = done_reg;
    end
  endgenerate
endmodule

// File: tb/tb_tick_sequencer.sv
// Randomized scoreboard bench for tick_sequencer: a time-based model predicts the absolute
// edge of every tick; a negedge monitor pops and compares as the DUT presents strobes.
module tb_tick_sequencer;
  localparam int NUM_CH   = 4;
  localparam int BASE_DIV = 4;
  localparam int PERIOD_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] stop;
  logic              base_tick;
  logic [NUM_CH-1:0] tick_out;
  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] done;

  tick_sequencer_if #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W)) cfg_if ();

  tick_sequencer #(.NUM_CH(NUM_CH), .BASE_DIV(BASE_DIV), .PERIOD_W(PERIOD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg       (cfg_if.slave),
    .start     (start),
    .stop      (stop),
    .base_tick (base_tick),
    .tick_out  (tick_out),
    .active    (active),
    .done      (done)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  // Reference model: configuration, run status and tick times as absolute edge numbers.
  int              m_period [NUM_CH];
  bit              m_os     [NUM_CH];
  bit [NUM_CH-1:0] m_run;
  bit [NUM_CH-1:0] m_done;
  int              r_per    [NUM_CH];
  bit              r_os     [NUM_CH];
  int              m_last   [NUM_CH];
  int              anchor = 0;   // first edge on which running channels count
  int              exp_q    [NUM_CH][$];

  task automatic chk(input string name, input int ch, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s ch=%0d edge=%0d: got %0d expected %0d", name, ch, edge_n, act, exp);
    end
  endtask

  function automatic int first_count(input int e0);
    if (e0 < anchor) return anchor;
    return anchor + ((e0 - anchor) / BASE_DIV + 1) * BASE_DIV;
  endfunction

  task automatic drop_from(input int ch, input int e);
    while (exp_q[ch].size() > 0 && exp_q[ch][exp_q[ch].size()-1] >= e)
      void'(exp_q[ch].pop_back());
  endtask

  // Apply the inputs sampled on the edge just taken to the model.
  task automatic model_edge();
    int e;
    int wch;
    bit ready_before;
    bit [NUM_CH-1:0] go;
    e = edge_n;
    if (rst) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        drop_from(ch, e);
        m_period[ch] = 0;
        m_os[ch]     = 1'b0;
      end
      m_run  = '0;
      m_done = '0;
      anchor = e + BASE_DIV + 1;
      return;
    end
    wch          = int'(cfg_if.cfg_ch);
    ready_before = !m_run[wch];
    go = '0;
    for (int ch = 0; ch < NUM_CH; ch++)
      go[ch] = start[ch] && !stop[ch] && !m_run[ch] && (m_period[ch] != 0);
`ifdef TICK_SEQ_SYNC_START_EN
    if (go != '0 && m_run == '0) anchor = e + BASE_DIV;
`endif
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (stop[ch]) begin
        if (m_run[ch]) drop_from(ch, e);
        m_run[ch]  = 1'b0;
        m_done[ch] = 1'b0;
      end else if (go[ch]) begin
        r_per[ch]  = m_period[ch];
        r_os[ch]   = m_os[ch];
        m_run[ch]  = 1'b1;
        m_done[ch] = 1'b0;
        m_last[ch] = first_count(e) + (r_per[ch] - 1) * BASE_DIV;
        exp_q[ch].push_back(m_last[ch]);
      end
    end
    if (cfg_if.cfg_valid && ready_before) begin
      m_period[wch] = int'(cfg_if.cfg_period);
      m_os[wch]     = cfg_if.cfg_oneshot;
      m_done[wch]   = 1'b0;
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (m_run[ch] && m_last[ch] == e) begin
        if (r_os[ch]) begin
          m_run[ch]  = 1'b0;
          m_done[ch] = 1'b1;
        end else begin
          m_last[ch] = e + r_per[ch] * BASE_DIV;
          exp_q[ch].push_back(m_last[ch]);
        end
      end
    end
  endtask

  // Monitor: compare presented strobes and status against the model every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      int bt_exp;
      bt_exp = (edge_n >= anchor - 1) && (((edge_n - (anchor - 1)) % BASE_DIV) == 0);
      chk("base_tick", 0, int'(base_tick), bt_exp);
      chk("cfg_ready", int'(cfg_if.cfg_ch), int'(cfg_if.cfg_ready),
          int'(!m_run[int'(cfg_if.cfg_ch)]));
      for (int ch = 0; ch < NUM_CH; ch++) begin
        chk("active", ch, int'(active[ch]), int'(m_run[ch]));
        chk("done", ch, int'(done[ch]), int'(m_done[ch]));
        if (tick_out[ch] !== 1'b0) begin
          if (exp_q[ch].size() == 0) begin
            chk("tick_unexpected", ch, int'(tick_out[ch]), 0);
          end else begin
            chk("tick_edge", ch, edge_n, exp_q[ch].pop_front());
          end
        end
        while (exp_q[ch].size() > 0 && exp_q[ch][0] < edge_n) begin
          chk("tick_missed", ch, 0, exp_q[ch][0]);
          void'(exp_q[ch].pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_cfg(input int ch, input int per, input bit os);
    cfg_if.cfg_valid   = 1'b1;
    cfg_if.cfg_ch      = 2'(ch);
    cfg_if.cfg_period  = PERIOD_W'(per);
    cfg_if.cfg_oneshot = os;
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [NUM_CH-1:0] m);
    start = m;
    step();
    start = '0;
  endtask

  task automatic pulse_stop(input logic [NUM_CH-1:0] m);
    stop = m;
    step();
    stop = '0;
  endtask

  initial begin
    int n;
    int left;
    rst = 1'b1;
    start = '0;
    stop = '0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch = '0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_oneshot = 1'b0;
    step();
    mon_en = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("reset_cfg_ready", 0, int'(cfg_if.cfg_ready), 1);
    chk("reset_outputs", 0, int'({tick_out, active, done, base_tick}), 0);

    // Zero period start is ignored.
    pulse_start(4'b0001);
    chk("zero_period_idle", 0, int'(active[0]), 0);

    // Continuous run, period 3.
    do_cfg(0, 3, 1'b0);
    idle($urandom_range(0, 5));
    pulse_start(4'b0001);
    idle(40);
    pulse_stop(4'b0001);

    // One-shot, period 2; then restart clears done.
    do_cfg(1, 2, 1'b1);
    pulse_start(4'b0010);
    n = 0;
    while (done[1] !== 1'b1 && n < 30) begin step(); n++; end
    chk("oneshot_done_wait", 1, int'(n < 30), 1);
    idle(6);
    chk("oneshot_done_hold", 1, int'(done[1]), 1);
    pulse_start(4'b0010);
    chk("oneshot_restart_clear", 1, int'(done[1]), 0);
    idle(12);

    // Stop on the completing base-tick edge with period 1.
    do_cfg(0, 1, 1'b0);
    pulse_start(4'b0001);
    idle($urandom_range(1, 3));
    n = 0;
    while (base_tick !== 1'b1 && n < 20) begin step(); n++; end
    chk("stop_bt_wait", 0, int'(n < 20), 1);
    pulse_stop(4'b0001);
    chk("stop_collide_active", 0, int'(active[0]), 0);
    idle(3);

    // Config lockout on a running channel; idle channel accepts.
    do_cfg(2, 4, 1'b0);
    pulse_start(4'b0100);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd2; cfg_if.cfg_period = 16'd2;
    cfg_if.cfg_oneshot = 1'b0;
    #1;
    chk("lockout_ready", 2, int'(cfg_if.cfg_ready), 0);
    step();
    cfg_if.cfg_ch = 2'd3;
    #1;
    chk("idle_ready", 3, int'(cfg_if.cfg_ready), 1);
    step();
    cfg_if.cfg_valid = 1'b0;
    pulse_start(4'b1000);
    idle(30);

    // Reset mid-run.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_outputs", 0, int'({tick_out, active, done, base_tick}), 0);
    chk("midrst_cfg_ready", 0, int'(cfg_if.cfg_ready), 1);
    idle(8);

    // Randomized traffic, including same-edge config/start collisions and resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_ch      = 2'($urandom_range(0, NUM_CH - 1));
        cfg_if.cfg_period  = PERIOD_W'($urandom_range(0, 6));
        cfg_if.cfg_oneshot = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 15) == 0) start = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 39) == 0) stop  = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
      step();
      cfg_if.cfg_valid = 1'b0;
      start = '0;
      stop  = '0;
      rst   = 1'b0;
    end

    pulse_stop('1);
    idle(4);
    left = 0;
    for (int ch = 0; ch < NUM_CH; ch++) left += exp_q[ch].size();
    chk("queue_drained", 0, left, 0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
